// File: rtl/debounce_pkg.sv
// -----------------------------------------------------------------------------
// debounce_pkg
//   Shared types and helpers for the multi-channel push-button debouncer.
//   - db_state_t : per-channel debounce FSM state
//   - cnt_width  : width of the window/hold counters for a given configuration
// -----------------------------------------------------------------------------
package debounce_pkg;

  typedef enum logic [1:0] {
    ST_LOW       = 2'd0,
    ST_PEND_HIGH = 2'd1,
    ST_HIGH      = 2'd2,
    ST_PEND_LOW  = 2'd3
  } db_state_t;

  // Both counters share one width, large enough to hold the bigger of the
  // debounce window and the long-press time (the hold counter saturates at
  // LONG_CYCLES itself, so the +1 is needed).
  function automatic int cnt_width(input int db_cycles, input int long_cycles);
    int m;
    m = (db_cycles > long_cycles) ? db_cycles : long_cycles;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/debouncer_channel.sv
// -----------------------------------------------------------------------------
// debouncer_channel
//   One debounced input: synchroniser, debounce FSM, window counter and
//   long-press hold counter. All outputs are registered.
// Ports
//   clk           in  system clock
//   reset         in  asynchronous, active-high reset
//   noisy_i       in  raw asynchronous input
//   debounced_o   out clean level
//   rise_o        out 1-cycle pulse on accepted 0->1
//   fall_o        out 1-cycle pulse on accepted 1->0
//   long_press_o  out 1-cycle pulse once per press after LONG_CYCLES in ST_HIGH
// -----------------------------------------------------------------------------
module debouncer_channel
  import debounce_pkg::*;
#(
  parameter int DB_CYCLES   = 2_000_000,
  parameter int LONG_CYCLES = 100_000_000,
  parameter bit EARLY       = 1'b0,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic noisy_i,
  output logic debounced_o,
  output logic rise_o,
  output logic fall_o,
  output logic long_press_o
);

  localparam int             CW        = cnt_width(DB_CYCLES, LONG_CYCLES);
  localparam bit             LONG_EN   = (LONG_CYCLES > 0);
  localparam logic [CW-1:0]  DB_LAST   = CW'(DB_CYCLES - 1);
  localparam logic [CW-1:0]  LONG_LAST = LONG_EN ? CW'(LONG_CYCLES - 1) : '0;
  localparam logic [CW-1:0]  LONG_SAT  = CW'(LONG_CYCLES);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;

  db_state_t     state_q, state_d;
  logic [CW-1:0] db_cnt_q, db_cnt_d;
  logic [CW-1:0] hold_q, hold_d;
  logic          deb_q, deb_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;
  logic          lp_q, lp_d;

  assign s = sync_q[SYNC_STAGES-1];

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // pre-edge values; blocking here would let the shift register collapse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], noisy_i};
  end

  always_comb begin
    // NOTE: every combinationally assigned signal gets a default first so no
    // path through the case leaves it unassigned (which would infer a latch).
    state_d  = state_q;
    db_cnt_d = db_cnt_q;
    deb_d    = deb_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;

    if (!EARLY) begin
      // Delayed accept: the input must stay at the new level for the full
      // window before the output follows.
      unique case (state_q)
        ST_LOW: if (s) state_d = ST_PEND_HIGH;
        ST_PEND_HIGH: begin
          if (!s) begin
            state_d = ST_LOW;
          end else if (db_cnt_q == DB_LAST) begin
            state_d = ST_HIGH;
            deb_d   = 1'b1;
            rise_d  = 1'b1;
          end else begin
            db_cnt_d = db_cnt_q + 1'b1;
          end
        end
        ST_HIGH: if (!s) state_d = ST_PEND_LOW;
        ST_PEND_LOW: begin
          if (s) begin
            state_d = ST_HIGH;
          end else if (db_cnt_q == DB_LAST) begin
            state_d = ST_LOW;
            deb_d   = 1'b0;
            fall_d  = 1'b1;
          end else begin
            db_cnt_d = db_cnt_q + 1'b1;
          end
        end
        default: state_d = ST_LOW;
      endcase
    end else begin
      // Early accept: follow the first edge immediately, then ignore the
      // input for the window so contact bounce cannot re-trigger.
      unique case (state_q)
        ST_LOW: if (s) begin
          state_d = ST_PEND_HIGH;
          deb_d   = 1'b1;
          rise_d  = 1'b1;
        end
        ST_PEND_HIGH: begin
          if (db_cnt_q == DB_LAST) state_d  = ST_HIGH;
          else                     db_cnt_d = db_cnt_q + 1'b1;
        end
        ST_HIGH: if (!s) begin
          state_d = ST_PEND_LOW;
          deb_d   = 1'b0;
          fall_d  = 1'b1;
        end
        ST_PEND_LOW: begin
          if (db_cnt_q == DB_LAST) state_d  = ST_LOW;
          else                     db_cnt_d = db_cnt_q + 1'b1;
        end
        default: state_d = ST_LOW;
      endcase
    end

    if (state_d != state_q) db_cnt_d = '0;
  end

  // Hold counter runs only while settled high; it stops at LONG_CYCLES so the
  // pulse condition (value LONG_CYCLES-1) is met exactly once per press.
  always_comb begin
    hold_d = hold_q;
    lp_d   = 1'b0;
    if (LONG_EN && state_q == ST_HIGH) begin
      if (hold_q != LONG_SAT)  hold_d = hold_q + 1'b1;
      if (hold_q == LONG_LAST) lp_d   = 1'b1;
    end
    if (state_d != state_q) hold_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_LOW;
      db_cnt_q <= '0;
      hold_q   <= '0;
      deb_q    <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      lp_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      db_cnt_q <= db_cnt_d;
      hold_q   <= hold_d;
      deb_q    <= deb_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      lp_q     <= lp_d;
    end
  end

  assign debounced_o  = deb_q;
  assign rise_o       = rise_q;
  assign fall_o       = fall_q;
  assign long_press_o = lp_q;

endmodule

// File: rtl/debouncer_multi.sv
// -----------------------------------------------------------------------------
// debouncer_multi
//   CHANNELS independent debouncers between the button/switch pads and the
//   counter/LED logic. No state is shared between channels.
// Ports
//   clk         in  system clock
//   reset       in  asynchronous, active-high reset
//   noisy       in  [CHANNELS] raw asynchronous inputs
//   debounced   out [CHANNELS] clean levels
//   rise        out [CHANNELS] 1-cycle pulse on accepted 0->1
//   fall        out [CHANNELS] 1-cycle pulse on accepted 1->0
//   long_press  out [CHANNELS] 1-cycle pulse once per press after LONG_CYCLES
// -----------------------------------------------------------------------------
module debouncer_multi
  import debounce_pkg::*;
#(
  parameter int CHANNELS    = 5,
  parameter int DB_CYCLES   = 2_000_000,
  parameter int LONG_CYCLES = 100_000_000,
  parameter bit EARLY       = 1'b0,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] noisy,
  output logic [CHANNELS-1:0] debounced,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic [CHANNELS-1:0] long_press
);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    debouncer_channel #(
      .DB_CYCLES   (DB_CYCLES),
      .LONG_CYCLES (LONG_CYCLES),
      .EARLY       (EARLY),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_ch (
      .clk          (clk),
      .reset        (reset),
      .noisy_i      (noisy[g]),
      .debounced_o  (debounced[g]),
      .rise_o       (rise[g]),
      .fall_o       (fall[g]),
      .long_press_o (long_press[g])
    );
  end

endmodule

// File: tb/tb_debouncer_multi.sv
// -----------------------------------------------------------------------------
// tb_debouncer_multi
//   Directed bench for debouncer_multi with CHANNELS=4, DB_CYCLES=8,
//   LONG_CYCLES=32, SYNC_STAGES=2. dut0 runs delayed-accept, dut1 early-accept.
//   Inputs change just after a falling edge; the next rising edge is edge 0.
//   Outputs are sampled on falling edges, so "after edge k" is k+1 steps.
// -----------------------------------------------------------------------------
module tb_debouncer_multi;

  localparam int CH = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [CH-1:0] noisy0, noisy1;
  logic [CH-1:0] deb0, rise0, fall0, lp0;
  logic [CH-1:0] deb1, rise1, fall1, lp1;

  int checks = 0;
  int errors = 0;

  int rise_n0 [CH] = '{default: 0};
  int fall_n0 [CH] = '{default: 0};
  int lp_n0   [CH] = '{default: 0};
  int rise_n1 [CH] = '{default: 0};
  int fall_n1 [CH] = '{default: 0};
  int both_n       = 0;

  always #5 clk = ~clk;

  debouncer_multi #(
    .CHANNELS(CH), .DB_CYCLES(8), .LONG_CYCLES(32), .EARLY(1'b0), .SYNC_STAGES(2)
  ) dut0 (
    .clk(clk), .reset(reset), .noisy(noisy0),
    .debounced(deb0), .rise(rise0), .fall(fall0), .long_press(lp0)
  );

  debouncer_multi #(
    .CHANNELS(CH), .DB_CYCLES(8), .LONG_CYCLES(32), .EARLY(1'b1), .SYNC_STAGES(2)
  ) dut1 (
    .clk(clk), .reset(reset), .noisy(noisy1),
    .debounced(deb1), .rise(rise1), .fall(fall1), .long_press(lp1)
  );

  // Pulse counters: sampled on the rising edge, i.e. the values held during
  // the previous cycle.
  always @(posedge clk) begin
    for (int c = 0; c < CH; c++) begin
      rise_n0[c] += int'(rise0[c]);
      fall_n0[c] += int'(fall0[c]);
      lp_n0[c]   += int'(lp0[c]);
      rise_n1[c] += int'(rise1[c]);
      fall_n1[c] += int'(fall1[c]);
      both_n     += int'(rise0[c] & fall0[c]) + int'(rise1[c] & fall1[c]);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset  = 1'b1;
    noisy0 = '0;
    noisy1 = '0;
    step(2);
    check("rst_deb0", 32'(deb0), 32'h0);
    check("rst_deb1", 32'(deb1), 32'h0);
    check("rst_pulses0", 32'(rise0 | fall0 | lp0), 32'h0);
    check("rst_pulses1", 32'(rise1 | fall1 | lp1), 32'h0);
    reset = 1'b0;
    step(3);

    // 1. Delayed accept on ch0, then release.
    noisy0 = 4'b0001;
    step(10);
    check("t1_deb_edge9", 32'(deb0), 32'h0);
    step(1);
    check("t1_deb_edge10", 32'(deb0), 32'h1);
    check("t1_rise_edge10", 32'(rise0), 32'h1);
    step(1);
    check("t1_rise_gone", 32'(rise0), 32'h0);
    check("t1_deb_held", 32'(deb0), 32'h1);
    check("t1_rise_cnt", 32'(rise_n0[0]), 32'd1);
    noisy0 = 4'b0000;
    step(10);
    check("t1_rel_edge9", 32'(deb0), 32'h1);
    step(1);
    check("t1_rel_edge10", 32'(deb0), 32'h0);
    check("t1_fall_edge10", 32'(fall0), 32'h1);
    step(1);
    check("t1_fall_gone", 32'(fall0), 32'h0);
    check("t1_no_long", 32'(lp_n0[0]), 32'd0);

    // 2. ch1 bounces every 3 cycles for 42 cycles, then settles high.
    for (int seg = 0; seg < 14; seg++) begin
      noisy0[1] = (seg % 2 == 0);
      step(3);
    end
    check("t2_bounce_deb", 32'(deb0), 32'h0);
    check("t2_bounce_rise", 32'(rise_n0[1]), 32'd0);
    check("t2_bounce_fall", 32'(fall_n0[1]), 32'd0);
    noisy0[1] = 1'b1;
    step(10);
    check("t2_deb_edge9", 32'(deb0), 32'h0);
    step(1);
    check("t2_deb_edge10", 32'(deb0), 32'h2);
    check("t2_rise_edge10", 32'(rise0), 32'h2);
    step(1);
    check("t2_rise_cnt", 32'(rise_n0[1]), 32'd1);
    noisy0[1] = 1'b0;
    step(12);
    check("t2_released", 32'(deb0), 32'h0);
    check("t2_fall_cnt", 32'(fall_n0[1]), 32'd1);
    check("t2_no_long", 32'(lp_n0[1]), 32'd0);

    // 4. ch3 long press, then re-press for a second long press.
    noisy0 = 4'b1000;
    step(11);
    check("t4_rise", 32'(rise0), 32'h8);
    step(31);
    check("t4_lp_edge41", 32'(lp0), 32'h0);
    step(1);
    check("t4_lp_edge42", 32'(lp0), 32'h8);
    step(1);
    check("t4_lp_gone", 32'(lp0), 32'h0);
    step(16);
    check("t4_lp_once", 32'(lp_n0[3]), 32'd1);
    noisy0 = 4'b0000;
    step(12);
    check("t4_released", 32'(deb0), 32'h0);
    noisy0 = 4'b1000;
    step(11);
    check("t4_rise2", 32'(rise0), 32'h8);
    step(32);
    check("t4_lp2_edge42", 32'(lp0), 32'h8);
    step(2);
    check("t4_lp_twice", 32'(lp_n0[3]), 32'd2);
    noisy0 = 4'b0000;
    step(12);

    // 5. Reset while ch0 is mid-window (cnt=4) and ch2 is settled high.
    noisy0 = 4'b0100;
    step(12);
    check("t5_ch2_high", 32'(deb0), 32'h4);
    noisy0 = 4'b0101;
    step(7);
    reset = 1'b1;
    #1;
    check("t5_async_deb", 32'(deb0), 32'h0);
    check("t5_async_pulses", 32'(rise0 | fall0 | lp0), 32'h0);
    step(1);
    reset = 1'b0;
    step(10);
    check("t5_deb_edge9", 32'(deb0), 32'h0);
    step(1);
    check("t5_deb_edge10", 32'(deb0), 32'h5);
    check("t5_rise_edge10", 32'(rise0), 32'h5);
    noisy0 = 4'b0000;
    step(12);

    // 3. Early accept on ch2 with bounce inside the lockout.
    noisy1 = 4'b0100;
    step(2);
    check("t3_deb_edge1", 32'(deb1), 32'h0);
    step(1);
    check("t3_deb_edge2", 32'(deb1), 32'h4);
    check("t3_rise_edge2", 32'(rise1), 32'h4);
    for (int i = 0; i < 6; i++) begin
      noisy1[2] = (i % 2 == 1);
      step(1);
    end
    step(10);
    check("t3_deb_settled", 32'(deb1), 32'h4);
    check("t3_single_rise", 32'(rise_n1[2]), 32'd1);
    check("t3_no_fall", 32'(fall_n1[2]), 32'd0);
    noisy1 = 4'b0000;
    step(2);
    check("t3_rel_edge1", 32'(deb1), 32'h4);
    step(1);
    check("t3_rel_edge2", 32'(deb1), 32'h0);
    check("t3_fall_edge2", 32'(fall1), 32'h4);
    step(12);
    check("t3_fall_cnt", 32'(fall_n1[2]), 32'd1);

    // 6. All channels of both DUTs press and release on the same edge.
    noisy0 = 4'hF;
    noisy1 = 4'hF;
    step(3);
    check("t6_rise1_all", 32'(rise1), 32'hF);
    step(8);
    check("t6_rise0_all", 32'(rise0), 32'hF);
    step(1);
    check("t6_rise0_gone", 32'(rise0), 32'h0);
    step(2);
    noisy0 = 4'h0;
    noisy1 = 4'h0;
    step(3);
    check("t6_fall1_all", 32'(fall1), 32'hF);
    step(8);
    check("t6_fall0_all", 32'(fall0), 32'hF);
    step(12);
    check("never_rise_and_fall", 32'(both_n), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
